// File: rtl/button_debounce_pkg.sv
// Shared types and default constants for the button debounce front end.
// Imported by sync2 and button_debounce.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHK_HI = 2'd1,
        HELD   = 2'd2,
        CHK_LO = 2'd3
    } deb_state_t;

    // 20 ms qualification, 0.5 s first repeat, 0.1 s repeat rate at 50 MHz
    localparam int DEB_CYCLES_DEF = 1000000;
    localparam int REP_DELAY_DEF  = 25000000;
    localparam int REP_PERIOD_DEF = 5000000;

    // Short qualification window so benches finish in a few dozen cycles
    localparam int SIM_DEB_CYCLES = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce_sync2.sv
// Two-flop synchronizer for the raw button level; clears to 0 on reset.
module sync2
    import debounce_pkg::*;
(
    input  logic clk_sys_i,
    input  logic rst_b_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    assign sync_d = {sync_q[0], d_i};
    assign q_o    = sync_q[1];

    // Shift the asynchronous level through two stages
    always_ff @(posedge clk_sys_i) begin
        if (!rst_b_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Button debounce: synchronizer, stable-sample qualification FSM, registered
// level/edge outputs and a strobe for the downstream enable flop.
// Build option: define BUTTON_DEBOUNCE_AUTOREPEAT_EN to add auto-repeat
// strobes while the button stays held.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | stable low, waiting for a synchronized 1
// CHK_HI | counting consecutive 1 samples toward acceptance
// HELD   | stable high (Level=1)
// CHK_LO | counting consecutive 0 samples toward release (Level=1)
module button_debounce
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEB_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REP_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REP_PERIOD_DEF
) (
    input  logic clk_sys_i,
    input  logic rst_b_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic strobe_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    // The last sample is consumed by the transition itself, so the counter
    // only has to reach DEBOUNCE_CYCLES-1 before the accepting sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    // Reject configurations that cannot qualify or cannot hold a count
    if (DEBOUNCE_CYCLES < 2 || REP_W < 1) begin : g_bad_cfg
        $error("button_debounce: DEBOUNCE_CYCLES must be >= 2 and repeat widths non-zero");
    end

    logic             btn_s;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync2 u_sync2 (
        .clk_sys_i (clk_sys_i),
        .rst_b_i   (rst_b_i),
        .d_i       (btn_i),
        .q_o       (btn_s)
    );

    // Qualification FSM: next state and debounce counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_HI: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_LO: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the outputs are registered
    always_comb begin
        level_d = (state_d == HELD) || (state_d == CHK_LO);
        rise_d  = (state_q == CHK_HI) && (state_d == HELD);
        fall_d  = (state_q == CHK_LO) && (state_d == IDLE);
    end

    // State, counter and output registers
    always_ff @(posedge clk_sys_i) begin
        if (!rst_b_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic             rep_stb_q, rep_stb_d;
    logic             hold_run;

    // The hold persists across CHK_LO bounces; only a return to IDLE ends it
    assign hold_run = ((state_q == HELD) || (state_q == CHK_LO)) &&
                      ((state_d == HELD) || (state_d == CHK_LO));

    // Repeat timer: counts cycles since Rise or the previous repeat strobe
    always_comb begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
        rep_stb_d   = 1'b0;
        if (rise_d) begin
            rep_cnt_d   = REP_W'(1);
            rep_first_d = 1'b1;
        end else if (hold_run) begin
            rep_first_d = rep_first_q;
            if (rep_cnt_q == (rep_first_q ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD))) begin
                rep_stb_d   = 1'b1;
                rep_cnt_d   = REP_W'(1);
                rep_first_d = 1'b0;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    // Repeat timer registers
    always_ff @(posedge clk_sys_i) begin
        if (!rst_b_i) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
            rep_stb_q   <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            rep_stb_q   <= rep_stb_d;
        end
    end

    assign strobe_o = rise_q | rep_stb_q;
`else
    assign strobe_o = rise_q;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Edge n is the n-th rising clock edge of a scenario.
module tb_button_debounce;
    import debounce_pkg::*;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic strobe;
    } exp_t;

    logic clk_sys;
    logic rst_b;
    logic btn;
    logic level_o, rise_o, fall_o, strobe_o;

    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;
    int    edge_n = 0;
    string scen = "none";

    button_debounce #(
        .DEBOUNCE_CYCLES (SIM_DEB_CYCLES),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk_sys_i (clk_sys),
        .rst_b_i   (rst_b),
        .btn_i     (btn),
        .level_o   (level_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .strobe_o  (strobe_o)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached at edge %0d of %s", edge_n, scen);
        $fatal(1, "watchdog");
    end

    task automatic check_outputs();
        exp_t x;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s scoreboard_empty edge=%0d", scen, edge_n);
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            total++;
            assert (level_o === x.level) else begin
                bad++;
                $error("FAIL %s level edge=%0d got=%b exp=%b", scen, edge_n, level_o, x.level);
            end
            total++;
            assert (rise_o === x.rise) else begin
                bad++;
                $error("FAIL %s rise edge=%0d got=%b exp=%b", scen, edge_n, rise_o, x.rise);
            end
            total++;
            assert (fall_o === x.fall) else begin
                bad++;
                $error("FAIL %s fall edge=%0d got=%b exp=%b", scen, edge_n, fall_o, x.fall);
            end
            total++;
            assert (strobe_o === x.strobe) else begin
                bad++;
                $error("FAIL %s strobe edge=%0d got=%b exp=%b", scen, edge_n, strobe_o, x.strobe);
            end
        end
    endtask

    // Drive one edge worth of inputs, queue what must appear after that edge
    task automatic cyc(input logic b, input logic r, input exp_t e);
        btn   = b;
        rst_b = r;
        sb.push_back(e);
        @(posedge clk_sys);
        edge_n++;
        #1;
        check_outputs();
    endtask

    initial begin
        btn   = 1'b0;
        rst_b = 1'b0;

        // Press sampled at 10, one-edge glitch at 20, release sampled at 30
        scen   = "press_release";
        edge_n = 0;
        for (int n = 1; n <= 40; n++) begin
            exp_t e;
            e.level = (n >= 15) && (n < 35);
            e.rise  = (n == 15);
            e.fall  = (n == 35);
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
            e.strobe = (n == 15) || (n == 25) || (n == 28) || (n == 31) || (n == 34);
`else
            e.strobe = (n == 15);
`endif
            cyc((n >= 10) && (n < 30) && (n != 20), n > 2, e);
        end

        // Short bounce never completes qualification
        scen   = "bounce";
        edge_n = 0;
        for (int n = 1; n <= 25; n++) begin
            exp_t e;
            e = '0;
            cyc((n == 10) || (n == 12), n > 2, e);
        end

        // Reset pulse at 13 while qualifying; first sampling edge after is 14
        scen   = "reset_mid_count";
        edge_n = 0;
        for (int n = 1; n <= 24; n++) begin
            exp_t e;
            e.level  = (n >= 19);
            e.rise   = (n == 19);
            e.fall   = 1'b0;
            e.strobe = (n == 19);
            cyc(n >= 10, !((n <= 2) || (n == 13)), e);
        end

        // Reset while HELD drops the level without a Fall pulse
        scen   = "reset_in_held";
        edge_n = 0;
        for (int n = 1; n <= 25; n++) begin
            exp_t e;
            e.level  = (n >= 10) && (n < 15);
            e.rise   = (n == 10);
            e.fall   = 1'b0;
            e.strobe = (n == 10);
            cyc((n >= 5) && (n < 15), !((n <= 2) || (n == 15)), e);
        end

        scen = "end";
        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL %s scoreboard_leftover got=%0d exp=0", scen, sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
